// File: rtl/i2c_byte_master_mod_if.sv
// Command/response handshake and open-drain line pins of the I2C byte engine.
// master = the byte engine, slave = the command source / pad side.
interface i2c_byte_master_mod_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_start_i;
    logic       cmd_stop_i;
    logic       cmd_read_i;
    logic       cmd_ack_i;
    logic [7:0] cmd_data_i;
    logic [7:0] dout_o;
    logic       ack_o;
    logic       done_o;
    logic       err_o;
    logic       busy_o;
    logic       scl_i;
    logic       sda_i;
    logic       scl_oe_o;
    logic       sda_oe_o;

    modport master (
        input  cmd_valid_i, cmd_start_i, cmd_stop_i, cmd_read_i, cmd_ack_i, cmd_data_i,
        input  scl_i, sda_i,
        output cmd_ready_o, dout_o, ack_o, done_o, err_o, busy_o, scl_oe_o, sda_oe_o
    );

    modport slave (
        output cmd_valid_i, cmd_start_i, cmd_stop_i, cmd_read_i, cmd_ack_i, cmd_data_i,
        output scl_i, sda_i,
        input  cmd_ready_o, dout_o, ack_o, done_o, err_o, busy_o, scl_oe_o, sda_oe_o
    );
endinterface

// File: rtl/i2c_byte_master_mod.sv
// Byte-level I2C master: START / 9 bit slots / STOP, one quarter per tick_i.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching with a timeout.
module i2c_byte_master_mod #(
    parameter int STRETCH_TIMEOUT = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tick_i,
    i2c_byte_master_mod_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] q, q_nxt;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic       stop_r, stop_nxt;
    logic       read_r, read_nxt;
    logic       mack_r, mack_nxt;
    logic [7:0] sh, sh_nxt;
    logic       ack_s, ack_s_nxt;
    logic       scl_oe, scl_oe_nxt;
    logic       sda_oe, sda_oe_nxt;
    logic [7:0] dout, dout_nxt;
    logic       ack_out, ack_out_nxt;
    logic       fin;
    logic       stall;
    logic       adv;
    logic [2:0] bit_idx;

`ifdef I2C_CLK_STRETCH_EN
    localparam int SW = $clog2(STRETCH_TIMEOUT + 1) + 1;
    logic [SW-1:0] st_cnt, st_cnt_nxt;
    logic          err_r, err_nxt;

    // A slave still holding SCL after we released it freezes the quarter.
    assign stall = tick_i && (state == S_BIT || state == S_STOP) && q == 2'd2 && !bus.scl_i;
`else
    logic unused_scl;

    assign stall      = 1'b0;
    assign unused_scl = bus.scl_i ^ (STRETCH_TIMEOUT == 0);
`endif

    assign adv     = tick_i && !stall;
    assign bit_idx = 3'd7 - bit_cnt[2:0];

    always_comb begin
        state_nxt   = state;
        q_nxt       = q;
        bit_cnt_nxt = bit_cnt;
        stop_nxt    = stop_r;
        read_nxt    = read_r;
        mack_nxt    = mack_r;
        sh_nxt      = sh;
        ack_s_nxt   = ack_s;
        scl_oe_nxt  = scl_oe;
        sda_oe_nxt  = sda_oe;
        dout_nxt    = dout;
        ack_out_nxt = ack_out;
        fin         = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
        st_cnt_nxt  = st_cnt;
        err_nxt     = err_r;
`endif
        unique case (state)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    stop_nxt    = bus.cmd_stop_i;
                    read_nxt    = bus.cmd_read_i;
                    mack_nxt    = bus.cmd_ack_i;
                    sh_nxt      = bus.cmd_data_i;
                    q_nxt       = 2'd0;
                    bit_cnt_nxt = 4'd0;
`ifdef I2C_CLK_STRETCH_EN
                    st_cnt_nxt  = '0;
                    err_nxt     = 1'b0;
`endif
                    state_nxt   = bus.cmd_start_i ? S_START : S_BIT;
                end
            end
            S_START: begin
                if (adv) begin
                    q_nxt      = q + 2'd1;
                    scl_oe_nxt = q[1];
                    sda_oe_nxt = (q != 2'd0);
                    if (q == 2'd3) state_nxt = S_BIT;
                end
            end
            S_BIT: begin
                if (adv) begin
                    q_nxt = q + 2'd1;
                    unique case (q)
                        2'd0: begin
                            scl_oe_nxt = 1'b1;
                            if (bit_cnt == 4'd8) sda_oe_nxt = read_r ? !mack_r : 1'b0;
                            else                 sda_oe_nxt = read_r ? 1'b0 : !sh[bit_idx];
                        end
                        2'd1: scl_oe_nxt = 1'b0;
                        2'd2: begin
                            // Read bits reuse the write byte register as shift-in.
                            if (bit_cnt == 4'd8) ack_s_nxt = bus.sda_i;
                            else if (read_r)     sh_nxt    = {sh[6:0], bus.sda_i};
                        end
                        2'd3: begin
                            scl_oe_nxt = 1'b1;
                            if (bit_cnt == 4'd8) begin
                                if (stop_r) state_nxt = S_STOP;
                                else        fin       = 1'b1;
                            end else begin
                                bit_cnt_nxt = bit_cnt + 4'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_STOP: begin
                if (adv) begin
                    q_nxt      = q + 2'd1;
                    scl_oe_nxt = (q == 2'd0);
                    sda_oe_nxt = !q[1];
                    if (q == 2'd3) fin = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (fin) begin
            state_nxt   = S_DONE;
            dout_nxt    = read_r ? sh : dout;
            ack_out_nxt = read_r ? 1'b0 : ack_s;
        end

`ifdef I2C_CLK_STRETCH_EN
        if (stall) begin
            st_cnt_nxt = st_cnt + 1'b1;
            if (st_cnt == SW'(STRETCH_TIMEOUT)) begin
                scl_oe_nxt = 1'b0;
                sda_oe_nxt = 1'b0;
                err_nxt    = 1'b1;
                state_nxt  = S_DONE;
            end
        end else if (adv && q == 2'd2) begin
            st_cnt_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            q       <= 2'd0;
            bit_cnt <= 4'd0;
            stop_r  <= 1'b0;
            read_r  <= 1'b0;
            mack_r  <= 1'b0;
            sh      <= 8'h00;
            ack_s   <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
            dout    <= 8'h00;
            ack_out <= 1'b0;
`ifdef I2C_CLK_STRETCH_EN
            st_cnt  <= '0;
            err_r   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            q       <= q_nxt;
            bit_cnt <= bit_cnt_nxt;
            stop_r  <= stop_nxt;
            read_r  <= read_nxt;
            mack_r  <= mack_nxt;
            sh      <= sh_nxt;
            ack_s   <= ack_s_nxt;
            scl_oe  <= scl_oe_nxt;
            sda_oe  <= sda_oe_nxt;
            dout    <= dout_nxt;
            ack_out <= ack_out_nxt;
`ifdef I2C_CLK_STRETCH_EN
            st_cnt  <= st_cnt_nxt;
            err_r   <= err_nxt;
`endif
        end
    end

    assign bus.cmd_ready_o = (state == S_IDLE);
    assign bus.busy_o      = (state != S_IDLE) && (state != S_DONE);
    assign bus.done_o      = (state == S_DONE);
    assign bus.dout_o      = dout;
    assign bus.ack_o       = ack_out;
    assign bus.scl_oe_o    = scl_oe;
    assign bus.sda_oe_o    = sda_oe;
`ifdef I2C_CLK_STRETCH_EN
    assign bus.err_o       = (state == S_DONE) && err_r;
`else
    assign bus.err_o       = 1'b0;
`endif
endmodule

// File: doc/i2c_byte_master_mod.md
Name: i2c_byte_master_mod

Overview:
- Byte-level I2C master engine that consumes the quarter-bit tick produced by the I2C clock controller.
- Generates START/STOP conditions, shifts one byte out or in MSB first, and samples or drives the ACK bit.
- Drives open-drain SCL/SDA pull-down enables toward the ADV7511 configuration bus.
- Sits between the clock controller (upstream) and the ADV7511 register-init sequencer (downstream command source).

Parameters:
STRETCH_TIMEOUT, 1023, maximum ticks a slave may hold SCL low before abort (used only with I2C_CLK_STRETCH_EN).

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-low (rst_i = 0 resets)
tick_i  input  1  one-clk_i-cycle pulse, 4 per SCL period, from I2C clock controller
cmd_valid_i  input  1  command request
cmd_ready_o  output  1  high only in IDLE; command accepted when valid & ready
cmd_start_i  input  1  prefix transfer with START
cmd_stop_i  input  1  suffix transfer with STOP
cmd_read_i  input  1  1 = read byte, 0 = write byte
cmd_ack_i  input  1  ACK bit master drives after read (0 = ACK, 1 = NACK)
cmd_data_i  input  8  write byte
dout_o  output  8  read byte, valid with done_o
ack_o  output  1  ACK sampled after write (0 = slave ACKed); 0 after read
done_o  output  1  one-cycle pulse at command completion
err_o  output  1  one-cycle pulse with done_o on stretch timeout
busy_o  output  1  high from acceptance until done_o
scl_i  input  1  SCL line readback
sda_i  input  1  SDA line readback
scl_oe_o  output  1  1 = pull SCL low, 0 = release
sda_oe_o  output  1  1 = pull SDA low, 0 = release

Behaviour:
- Reset values: cmd_ready_o=1; busy_o, done_o, err_o, ack_o, scl_oe_o, sda_oe_o = 0; dout_o=0x00; FSM=IDLE; quarter counter q=0; bit counter=0.
- States: IDLE -> START (if cmd_start_i) -> BIT x9 -> STOP (if cmd_stop_i) -> DONE -> IDLE.
- Command fields are latched on acceptance. The first phase executes on the first tick_i strictly after the acceptance cycle; a tick in the acceptance cycle is ignored.
- Every state advances one quarter (q=0..3) per tick_i. No progress without tick_i.
- START quarters (SCL,SDA released=1): q0 1,1; q1 1,0; q2 0,0; q3 0,0.
- BIT quarters:
  - q0: SCL low, SDA set to the bit value.
  - q1, q2: SCL high. sda_i is sampled on the q2 tick.
  - q3: SCL low.
- Write: bits 7..0 of the byte driven; 9th bit SDA released, sample -> ack_o.
- Read: SDA released for 8 bits, samples shifted MSB-first into the byte; 9th bit drives cmd_ack_i.
- STOP quarters: q0 0,0; q1 1,0; q2 1,1; q3 1,1.
- Without STOP, SCL is left low (held) at the end of the 9th bit, ready for a repeated START or the next byte.
- done_o pulses in the clk_i cycle after the final quarter tick; dout_o and ack_o are updated in that same cycle and hold until the next done_o.
- Tick counts (no stretch): write or read with START+STOP = 44 ticks; START only = 40; neither = 36.
- cmd_valid_i while busy: ignored, not queued.
- rst_i low mid-transfer: both lines released immediately (asynchronous), FSM to IDLE, no STOP generated, no done_o.

Optional Feature:
I2C_CLK_STRETCH_EN
- Defined:
  - Entering any SCL-high quarter (BIT q1, STOP q1) with scl_i still low freezes the quarter counter; ticks are counted instead.
  - Release resumes normal stepping.
  - If the count exceeds STRETCH_TIMEOUT: release both lines, pulse done_o and err_o together, return to IDLE.
- Undefined: scl_i is ignored and err_o is tied 0.

Test Plan:
- Write 0x72, START, no STOP, sda_i=0 at 9th bit.
  - Required: SDA pattern 0,1,1,1,0,0,1,0 on SCL highs.
  - Required: ack_o=0 and done_o after 40 ticks; SCL held low.
- Read, START+STOP, cmd_ack_i=1, slave drives 0xA5.
  - Required: dout_o=0xA5, ack_o=0, SDA released on the 9th bit.
  - Required: STOP seen (SDA rises while SCL high); done_o after 44 ticks.
- Write 0x41, no START/STOP, sda_i held 1.
  - Required: ack_o=1, done_o after 36 ticks.
- rst_i low during bit 4 of a write.
  - Required: scl_oe_o=sda_oe_o=0 in the same cycle; no done_o.
  - Required: cmd_ready_o=1 after release.
- cmd_valid_i coincident with tick_i, then a second cmd_valid_i pulse mid-transfer.
  - Required: first phase starts on the next tick; second command ignored.
- With I2C_CLK_STRETCH_EN: hold scl_i low for 20 ticks in bit 2, then release.
  - Required: completion delayed by 20 ticks, err_o=0.
  - Required: a hold of 1100 ticks gives err_o=1 with done_o.
